// File: rtl/vend_if.sv
// vend_if: request/handshake and datapath-control bundle for vend_controller; cancel exists only when VEND_CANCEL_EN is defined
interface vend_if;
  logic item_valid;
  logic [1:0] item_req;
  logic coin_valid;
  logic [1:0] coin_code;
  logic lt, gt, eq;
  logic change_ack;
`ifdef VEND_CANCEL_EN
  logic cancel;
`endif
  logic ld_item, ld_price, ld_bal, ld_coin;
  logic [1:0] item_sel, coin_sel, bal_sel;
  logic item_ready, coin_ready, dispense, change_req, refund;
  modport master (
`ifdef VEND_CANCEL_EN
    output cancel,
`endif
    output item_valid, item_req, coin_valid, coin_code, lt, gt, eq, change_ack,
    input ld_item, ld_price, ld_bal, ld_coin, item_sel, coin_sel, bal_sel,
    input item_ready, coin_ready, dispense, change_req, refund
  );
  modport slave (
`ifdef VEND_CANCEL_EN
    input cancel,
`endif
    input item_valid, item_req, coin_valid, coin_code, lt, gt, eq, change_ack,
    output ld_item, ld_price, ld_bal, ld_coin, item_sel, coin_sel, bal_sel,
    output item_ready, coin_ready, dispense, change_req, refund
  );
endinterface

// File: rtl/vend_controller.sv
// vend_controller: vending-machine control FSM with inactivity-timeout refund; VEND_CANCEL_EN adds a cancel input
module vend_controller #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset,
  vend_if.slave ctl
);
  typedef enum logic [3:0] {IDLE, PRICE, WAIT_COIN, ADD, CHECK, VEND, CHANGE, REFUND, CLEAR} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic bal_nz_q, bal_nz_d, change_due_q, change_due_d, quit;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      bal_nz_q <= 1'b0;
      change_due_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bal_nz_q <= bal_nz_d;
      change_due_q <= change_due_d;
    end
  end
`ifdef VEND_CANCEL_EN
  assign quit = ctl.cancel || timer_q == CNT_W'(TIMEOUT_CYCLES - 1);
`else
  assign quit = timer_q == CNT_W'(TIMEOUT_CYCLES - 1);
`endif
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bal_nz_d = bal_nz_q;
    change_due_d = change_due_q;
    ctl.ld_item = 1'b0;
    ctl.ld_price = 1'b0;
    ctl.ld_bal = 1'b0;
    ctl.ld_coin = 1'b0;
    ctl.item_sel = 2'd0;
    ctl.coin_sel = 2'd0;
    ctl.bal_sel = 2'd3;
    ctl.item_ready = state_q == IDLE;
    ctl.coin_ready = state_q == WAIT_COIN;
    ctl.dispense = state_q == VEND;
    ctl.change_req = state_q inside {CHANGE, REFUND};
    ctl.refund = state_q == REFUND;
    case (state_q)
      IDLE: if (ctl.item_valid) begin
        ctl.ld_item = 1'b1;
        ctl.item_sel = ctl.item_req;
        state_d = PRICE;
      end
      PRICE: begin
        ctl.ld_price = 1'b1;
        timer_d = '0;
        state_d = WAIT_COIN;
      end
      WAIT_COIN: if (ctl.coin_valid) begin
        ctl.ld_coin = 1'b1;
        ctl.coin_sel = ctl.coin_code;
        timer_d = '0;
        bal_nz_d = bal_nz_q || ctl.coin_code != 2'd0;
        state_d = ADD;
      end else if (quit) state_d = bal_nz_q ? REFUND : CLEAR;
      else timer_d = timer_q + 1'b1;
      ADD: begin
        ctl.ld_bal = 1'b1;
        ctl.bal_sel = 2'd1;
        state_d = CHECK;
      end
      CHECK: if (ctl.lt) begin
        timer_d = '0;
        state_d = WAIT_COIN;
      end else begin
        change_due_d = ctl.gt && !ctl.eq;
        state_d = VEND;
      end
      VEND: begin
        ctl.ld_bal = 1'b1;
        ctl.bal_sel = 2'd2;
        state_d = change_due_q ? CHANGE : CLEAR;
      end
      CHANGE, REFUND: if (ctl.change_ack) state_d = CLEAR;
      CLEAR: begin
        ctl.ld_bal = 1'b1;
        ctl.bal_sel = 2'd0;
        bal_nz_d = 1'b0;
        change_due_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_vend_controller.sv
// tb_vend_controller: random sales/abandons scored against a transaction-level model with a bench-side datapath
module tb_vend_controller;
  localparam int T = 24;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  vend_if bus();
  vend_controller #(.TIMEOUT_CYCLES(T), .CNT_W(16)) dut (.clk(clk), .reset(reset), .ctl(bus));
  // kind: 0 exact sale, 1 sale with change, 2 refund, 3 abandon with nothing to return
  typedef struct {int kind; int cyc; int amt;} exp_t;
  exp_t expq[$];
  exp_t cur;
  int checks = 0, errors = 0, cyc = 0;
  int price_of[4] = '{10, 20, 50, 100};
  int coin_of[4] = '{0, 5, 10, 20};
  int codes[64];
  int nc, ack_wait, disp_cyc;
  bit mon_en = 1'b0, ack_en = 1'b0, act = 1'b0, seen_chg = 1'b0, prev_cr = 1'b0;
  logic [1:0] dp_item;
  logic [7:0] dp_price, dp_coin, dp_bal;
  assign bus.lt = dp_bal < dp_price;
  assign bus.gt = dp_bal > dp_price;
  assign bus.eq = dp_bal == dp_price;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      dp_item <= 2'd0;
      dp_price <= 8'd0;
      dp_coin <= 8'd0;
      dp_bal <= 8'd0;
    end else begin
      if (bus.ld_item) dp_item <= bus.item_sel;
      if (bus.ld_price) dp_price <= 8'(price_of[dp_item]);
      if (bus.ld_coin) dp_coin <= 8'(coin_of[bus.coin_sel]);
      if (bus.ld_bal) dp_bal <= bus.bal_sel == 2'd0 ? 8'd0 : bus.bal_sel == 2'd1 ? dp_bal + dp_coin :
                                bus.bal_sel == 2'd2 ? dp_bal - dp_price : dp_bal;
    end
  end
  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d at cycle %0d", name, got, want, cyc);
    end
  endtask
  task automatic hang(input string what);
    checks++;
    errors++;
    $display("FAIL wait_%s timed out at cycle %0d", what, cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "stalled");
  endtask
  task automatic take();
    chk("exp_pending", int'(expq.size() > 0), 1);
    cur = expq.size() > 0 ? expq.pop_front() : '{9, -1, -1};
  endtask
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (bus.ld_item) chk("bal_cleared", dp_bal, 0);
      if (bus.dispense) begin
        take();
        act = 1'b1;
        seen_chg = 1'b0;
        disp_cyc = cyc;
        chk("disp_kind", int'(cur.kind < 2), 1);
        chk("disp_cycle", cyc, cur.cyc);
      end
      if (bus.change_req && !prev_cr) begin
        if (bus.refund) begin
          take();
          act = 1'b1;
          chk("refund_kind", cur.kind, 2);
          chk("refund_cycle", cyc, cur.cyc);
          chk("refund_amt", dp_bal, cur.amt);
        end else begin
          chk("change_kind", act ? cur.kind : -1, 1);
          chk("change_cycle", cyc, disp_cyc + 1);
          chk("change_amt", dp_bal, cur.amt);
        end
        seen_chg = 1'b1;
      end
      if (bus.ld_bal && bus.bal_sel == 2'd0) begin
        if (!act) begin
          take();
          chk("abandon_kind", cur.kind, 3);
          chk("abandon_cycle", cyc, cur.cyc);
        end else begin
          chk("change_seen", seen_chg, cur.kind != 0);
          if (cur.kind == 0) chk("exact_clear_cycle", cyc, disp_cyc + 1);
        end
        act = 1'b0;
      end
    end
    prev_cr = bus.change_req;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.change_ack = 1'b0;
    ack_wait = -1;
    forever begin
      step();
      if (!ack_en) begin
        bus.change_ack = 1'b0;
        ack_wait = -1;
      end else if (bus.change_ack) bus.change_ack = 1'b0;
      else if (bus.change_req) begin
        if (ack_wait < 0) ack_wait = int'($urandom % 4);
        if (ack_wait == 0) begin
          bus.change_ack = 1'b1;
          ack_wait = -1;
        end else ack_wait--;
      end else bus.change_ack = ($urandom % 8) == 0;
    end
  end
  task automatic noise();
    bus.item_valid = !bus.item_ready && ($urandom % 4) == 0;
    bus.item_req = 2'($urandom);
    bus.coin_valid = !bus.coin_ready && ($urandom % 4) == 0;
    bus.coin_code = 2'($urandom);
  endtask
  task automatic quiet();
    bus.item_valid = 1'b0;
    bus.coin_valid = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (!bus.item_ready) begin
      noise();
      step();
      n++;
      if (n > 4 * T + 200) hang("item_ready");
    end
    quiet();
  endtask
  task automatic run_txn(input int item, input bit use_cancel);
    int sum = 0, base, k, g, n, p;
    bit sold = 1'b0;
    p = price_of[item];
    wait_idle();
    bus.item_valid = 1'b1;
    bus.item_req = 2'(item);
    base = cyc + 2 + T;
    step();
    bus.item_valid = 1'b0;
    for (int j = 0; j < nc && !sold; j++) begin
      g = int'($urandom % 4);
      n = 0;
      while (1) begin
        if (bus.coin_ready && g == 0) break;
        if (bus.coin_ready) begin
          g--;
          quiet();
        end else noise();
        step();
        n++;
        if (n > 50) hang("coin_ready");
      end
      bus.item_valid = 1'b0;
      bus.coin_valid = 1'b1;
      bus.coin_code = 2'(codes[j]);
      k = cyc;
      sum += coin_of[codes[j]];
      if (sum >= p) begin
        sold = 1'b1;
        expq.push_back('{sum > p ? 1 : 0, k + 3, sum - p});
      end
      base = k + 3 + T;
      step();
      bus.coin_valid = 1'b0;
    end
    if (!sold) begin
`ifdef VEND_CANCEL_EN
      if (use_cancel) begin
        n = 0;
        while (!bus.coin_ready) begin
          noise();
          step();
          n++;
          if (n > 50) hang("cancel");
        end
        quiet();
        bus.cancel = 1'b1;
        base = cyc + 1;
      end
`endif
      expq.push_back('{sum > 0 ? 2 : 3, base, sum});
`ifdef VEND_CANCEL_EN
      step();
      bus.cancel = 1'b0;
`endif
    end
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end
  initial begin
    int item, p, s, c, n;
    quiet();
    bus.item_req = 2'd0;
    bus.coin_code = 2'd0;
`ifdef VEND_CANCEL_EN
    bus.cancel = 1'b0;
`endif
    step();
    step();
    reset = 1'b0;
    chk("reset_outputs", int'({bus.item_ready, bus.coin_ready, bus.dispense, bus.change_req, bus.refund,
        bus.ld_item, bus.ld_price, bus.ld_bal, bus.ld_coin, bus.bal_sel}), int'(11'b100_0000_0011));
    bus.item_valid = 1'b1;
    bus.item_req = 2'd0;
    step();
    bus.item_valid = 1'b0;
    n = 0;
    while (!bus.coin_ready) begin step(); n++; if (n > 10) hang("dir_coin"); end
    bus.coin_valid = 1'b1;
    bus.coin_code = 2'd3;
    step();
    bus.coin_valid = 1'b0;
    n = 0;
    while (!bus.change_req) begin step(); n++; if (n > 10) hang("dir_change"); end
    step();
    step();
    chk("change_held", bus.change_req, 1);
    chk("change_bal_dir", dp_bal, 10);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("reset_mid_change", int'({bus.item_ready, bus.coin_ready, bus.dispense, bus.change_req, bus.refund,
        bus.ld_item, bus.ld_price, bus.ld_bal, bus.ld_coin, bus.bal_sel}), int'(11'b100_0000_0011));
    step();
    mon_en = 1'b1;
    ack_en = 1'b1;
    codes[0] = 3; nc = 1; run_txn(1, 1'b0);
    codes[0] = 3; nc = 1; run_txn(0, 1'b0);
    for (int i = 0; i < 5; i++) codes[i] = 3;
    nc = 5; run_txn(3, 1'b0);
    codes[0] = 2; nc = 1; run_txn(2, 1'b0);
    nc = 0; run_txn(2, 1'b0);
    codes[0] = 0; nc = 1; run_txn(2, 1'b0);
`ifdef VEND_CANCEL_EN
    codes[0] = 1; nc = 1; run_txn(2, 1'b1);
`endif
    repeat (40) begin
      item = int'($urandom % 4);
      p = price_of[item];
      s = 0;
      nc = 0;
      if (($urandom % 3) != 0) begin
        while (s < p && nc < 64) begin
          c = int'($urandom % 4);
          codes[nc] = c;
          nc++;
          s += coin_of[c];
        end
      end else begin
        n = int'($urandom % 4);
        for (int i = 0; i < n; i++) begin
          c = int'($urandom % 4);
          if (s + coin_of[c] < p) begin
            codes[nc] = c;
            nc++;
            s += coin_of[c];
          end
        end
      end
      run_txn(item, ($urandom % 2) == 0);
    end
    wait_idle();
    step();
    step();
    chk("queue_empty", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
